exception_unit: RTL
===================

# exception_unit

Exception and interrupt front end for the multi-cycle CPU. It sits beside the main controller and feeds it:
- It produces `exp_flag`, which the controller samples in WB.
- It holds the exception PC (EPC) and cause for the write-back path.
- It supplies the PC-mux target used when the controller selects `PCSource = 2'b11`.

It consumes the controller's `exp_write` / `exp_state` / `PCWrite` / `PCSource` outputs, the ALU overflow indication and an asynchronous external interrupt line.

## Interface
- `EXC_VECTOR`, default 32'h0000_0080: handler entry address.
- `COUNT_W`, default 8: width of the exception counter.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `exp_write` in 1: controller arm strobe, high for one cycle in EX of R-type and I-type arithmetic.
- `exp_state` in 1: controller mode; 1 = errproc return path, 0 = exception entry path.
- `pc_write` in 1: controller PCWrite.
- `pc_source` in 2: controller PCSource.
- `pc_in` in 32: current PC register value (already PC+4 after IF).
- `alu_ovf` in 1: ALU signed overflow for the current operation.
- `signed_op` in 1: 1 when the current operation traps on overflow (add, sub, addi).
- `irq_in` in 1: external interrupt, asynchronous, rising-edge significant.
- `exp_flag` out 1: exception request to the controller.
- `exc_pc` out 32: PC-mux input for `PCSource = 11`.
- `epc` out 32: saved exception PC, feeding the `MemtoReg = 11` path.
- `cause` out 2: 00 none, 01 overflow, 10 interrupt.
- `kernel` out 1: 1 while inside the handler.
- `exc_count` out `COUNT_W`: saturating count of exceptions taken.

## Operation
- **IRQ synchronizer:** two flops `s1`, `s2`, plus a delayed copy `s3`.
  - `rise = s2 & ~s3`.
  - `rise` sets `irq_pend`.
  - `irq_pend` is cleared only when an interrupt entry is taken.
- **Trap condition:** `ovf_trap = alu_ovf & signed_op`.
- **Event decodes:**
  - `entry = pc_write & (pc_source == 2'b11) & ~exp_state`.
  - `ret = pc_write & (pc_source == 2'b11) & exp_state`.
- **`exp_flag` register:**
  - On an `exp_write` cycle: `exp_flag <= ~kernel & (ovf_trap | irq_pend)`.
  - Else on `entry`: cleared.
  - Else: holds.
- **Cause selection:** `pend_cause` is latched on the same `exp_write` cycle.
  - Overflow has priority: 01 if `ovf_trap`, else 10.
  - An IRQ that loses to overflow stays pending.
- **On `entry`:**
  - `epc <= pc_in - 32'd4` (address of the faulting instruction, modulo 2^32).
  - `cause <= pend_cause`.
  - `kernel <= 1`.
  - `irq_pend` cleared only if `pend_cause == 10`.
  - `exc_count` increments, saturating at all-ones.
- **On `ret`:** `kernel <= 0`. `epc` and `cause` are held.
- **`exc_pc`** is combinational: `exp_state ? epc : EXC_VECTOR`.
- **While `kernel = 1`:** no new exception is raised. Interrupt edges still set `irq_pend` and are taken at the first `exp_write` after return.
- **Entry while `exp_flag = 0`:** never generated by the controller. If it occurs, `cause` takes `pend_cause` as latched.
- **Reset (asynchronous, `reset` low):**
  - `s1`, `s2`, `s3`, `irq_pend`, `exp_flag`, `kernel`, `exc_count` = 0.
  - `epc` = 0, `cause` = 00.
  - `exc_pc` therefore reads `EXC_VECTOR`, with `exp_state` low.
  - Reset mid-exception abandons the exception completely; no state survives.

## Timing
- `exp_write` high at edge T → `exp_flag` valid after T. The controller samples it in WB, cycle T+1.
- Entry edge (end of WB) → `exp_flag` = 0, `kernel` = 1, `epc` / `cause` valid in the next cycle.
- `irq_in` rising → `irq_pend` set 3 rising edges later. The input must be high for at least 2 clocks to be seen.
- Entry and `rise` on the same edge: the new edge sets `irq_pend` after clearing. Set wins; the interrupt is not lost.
- `ret` and `exp_write` never coincide. `exp_write` sees the old `kernel` value.
- `exc_pc` has zero latency from `exp_state` / `epc`.

## Test plan
- **Overflow trap:** `pc_in` = 0x0000_0104, `signed_op` = 1, `alu_ovf` = 1, `exp_write` pulse → `exp_flag` = 1 next cycle; entry pulse → `epc` = 0x0000_0100, `cause` = 01, `kernel` = 1, `exc_pc` = 0x80, `exc_count` = 1.
- **Unsigned overflow:** `signed_op` = 0, `alu_ovf` = 1, `exp_write` → `exp_flag` stays 0 and `exc_count` is unchanged.
- **Interrupt:** `irq_in` 0→1 held 3 cycles, then `exp_write` → `exp_flag` = 1; entry → `cause` = 10, `irq_pend` cleared; `ret` with `exp_state` = 1 → `kernel` = 0 and `exc_pc` = `epc`.
- **Masking and priority:**
  - Interrupt edge while `kernel` = 1 → no `exp_flag`; after `ret`, the next `exp_write` → `exp_flag` = 1, `cause` = 10.
  - Overflow and `irq_pend` together → `cause` = 01; the interrupt is taken on the following arm.
- **Saturation:** `COUNT_W` = 2, five entry/ret pairs → `exc_count` = 3.
- **Reset:** async `reset` low mid-handler (`kernel` = 1, `exp_flag` = 1) → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/exception_unit_if.sv
// Controller-side bundle for the exception unit: arm/entry/return strobes,
// PC and ALU status in, exception flag, PC-mux target and saved state out.
interface exception_unit_if #(
    parameter int COUNT_W = 8
);
    logic                exp_write;
    logic                exp_state;
    logic                pc_write;
    logic [1:0]          pc_source;
    logic [31:0]         pc_in;
    logic                alu_ovf;
    logic                signed_op;
    logic                irq_in;
    logic                exp_flag;
    logic [31:0]         exc_pc;
    logic [31:0]         epc;
    logic [1:0]          cause;
    logic                kernel;
    logic [COUNT_W-1:0]  exc_count;

    modport master (
        output exp_write, exp_state, pc_write, pc_source, pc_in,
               alu_ovf, signed_op, irq_in,
        input  exp_flag, exc_pc, epc, cause, kernel, exc_count
    );

    modport slave (
        input  exp_write, exp_state, pc_write, pc_source, pc_in,
               alu_ovf, signed_op, irq_in,
        output exp_flag, exc_pc, epc, cause, kernel, exc_count
    );
endinterface

// File: rtl/exception_unit.sv
// Exception/interrupt front end for the multi-cycle CPU: arms exp_flag,
// records EPC and cause on handler entry, and supplies the PC-mux target.
module exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int          COUNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    exception_unit_if.slave  bus
);
    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_IRQ  = 2'b10;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic               s1_r, s2_r, s3_r;
    logic               irq_pend_r;
    logic               exp_flag_r;
    logic               kernel_r;
    logic [1:0]         pend_cause_r;
    logic [1:0]         cause_r;
    logic [31:0]        epc_r;
    logic [COUNT_W-1:0] count_r;

    logic rise_s, ovf_trap_s, pc_mux_s, entry_s, ret_s;

    assign rise_s     = s2_r & ~s3_r;
    assign ovf_trap_s = bus.alu_ovf & bus.signed_op;
    assign pc_mux_s   = bus.pc_write & (bus.pc_source == 2'b11);
    assign entry_s    = pc_mux_s & ~bus.exp_state;
    assign ret_s      = pc_mux_s & bus.exp_state;

    // Two-flop synchronizer for irq_in plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= bus.irq_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Pending interrupt: a new edge wins over the clear from an IRQ entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_pend_r <= 1'b0;
        end else if (rise_s) begin
            irq_pend_r <= 1'b1;
        end else if (entry_s && (pend_cause_r == CAUSE_IRQ)) begin
            irq_pend_r <= 1'b0;
        end else begin
            irq_pend_r <= irq_pend_r;
        end
    end

    // Exception request and its cause, armed on the controller's EX strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_flag_r   <= 1'b0;
            pend_cause_r <= CAUSE_NONE;
        end else if (bus.exp_write) begin
            exp_flag_r   <= ~kernel_r & (ovf_trap_s | irq_pend_r);
            pend_cause_r <= ovf_trap_s ? CAUSE_OVF : CAUSE_IRQ;
        end else if (entry_s) begin
            exp_flag_r   <= 1'b0;
            pend_cause_r <= pend_cause_r;
        end else begin
            exp_flag_r   <= exp_flag_r;
            pend_cause_r <= pend_cause_r;
        end
    end

    // Handler entry captures EPC/cause and enters kernel mode; return leaves it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_r    <= 32'h0000_0000;
            cause_r  <= CAUSE_NONE;
            kernel_r <= 1'b0;
            count_r  <= '0;
        end else if (entry_s) begin
            // pc_in is already PC+4, so back up to the faulting instruction.
            epc_r    <= bus.pc_in - 32'd4;
            cause_r  <= pend_cause_r;
            kernel_r <= 1'b1;
            count_r  <= sat_inc(count_r);
        end else if (ret_s) begin
            epc_r    <= epc_r;
            cause_r  <= cause_r;
            kernel_r <= 1'b0;
            count_r  <= count_r;
        end else begin
            epc_r    <= epc_r;
            cause_r  <= cause_r;
            kernel_r <= kernel_r;
            count_r  <= count_r;
        end
    end

    assign bus.exp_flag  = exp_flag_r;
    assign bus.epc       = epc_r;
    assign bus.cause     = cause_r;
    assign bus.kernel    = kernel_r;
    assign bus.exc_count = count_r;
    assign bus.exc_pc    = bus.exp_state ? epc_r : EXC_VECTOR;
endmodule
